cassette_save: RTL and testbench
================================

CASSETTE_SAVE -- requirements
Module: cassette_save

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, single-cycle request to begin a save; sampled only in IDLE.
REQ-004 SHALL have port abort, input, 1, forces return to IDLE from any state.
REQ-005 SHALL have port file_type, input, 8, TAP type byte (0x00 BASIC, 0x80 machine code); latched at start.
REQ-006 SHALL have port autorun, input, 1, latched at start; emitted as 0xC7 if 1, 0x00 if 0.
REQ-007 SHALL have ports start_addr / end_addr, input, 16 each, inclusive RAM range; latched at start.
REQ-008 SHALL have ports mem_addr (output, 16), mem_rd (output, 1) and mem_din (input, 8); read data valid exactly 1 cycle after mem_rd.
REQ-009 SHALL have ports out_data (output, 8), out_valid (output, 1) and out_ready (input, 1); a byte transfers on a cycle with out_valid && out_ready.
REQ-010 SHALL have port out_addr, output, 25, byte offset of out_data within the file.
REQ-011 SHALL have ports busy, done and error, output, 1 each.

Function
REQ-012 SHALL implement states IDLE, HEADER, NAME (macro only), FETCH, WAIT, SEND, DONE.
REQ-013 On start in IDLE with end_addr >= start_addr, SHALL latch inputs, clear out_addr to 0, assert busy and enter HEADER next cycle.
REQ-014 On start in IDLE with end_addr < start_addr, SHALL pulse error for 1 cycle, emit nothing and stay in IDLE.
REQ-015 HEADER SHALL emit offsets 0..12: 16 16 16 24 00 00 type auto endHi endLo startHi startLo 00.
REQ-016 After header (and NAME when enabled), SHALL emit one 0x00 name terminator at the next offset.
REQ-017 Data phase SHALL assert mem_rd with mem_addr = current pointer (FETCH), capture mem_din (WAIT), then present it on out_data (SEND).
REQ-018 Data phase SHALL emit end_addr - start_addr + 1 bytes, start_addr through end_addr inclusive.
REQ-019 SHALL keep out_data and out_addr stable while out_valid && !out_ready.
REQ-020 SHALL increment out_addr by 1 on every accepted byte, never otherwise.
REQ-021 SHALL stop after accepting byte end_addr, including end_addr = 0xFFFF; the 16-bit pointer wrap SHALL NOT cause extra reads.
REQ-022 SHALL compute the data-phase byte count in 17 bits, so a full 0x0000..0xFFFF range emits 65536 bytes.
REQ-023 DONE SHALL pulse done for exactly 1 cycle, deassert busy and return to IDLE; out_addr SHALL hold the total file length.
REQ-024 abort SHALL take priority over all other events, deassert out_valid, mem_rd and busy next cycle, and SHALL NOT pulse done.
REQ-025 start asserted while busy SHALL be ignored.
REQ-026 mem_rd SHALL be high only in FETCH, for 1 cycle per data byte.

Reset
REQ-027 On reset_n low SHALL immediately enter IDLE, with all outputs 0: out_valid, mem_rd, busy, done, error, out_data, out_addr, mem_addr.
REQ-028 Reset mid-transfer SHALL discard the partial file; no done pulse on release.

Configuration
REQ-029 Macro CASSETTE_SAVE_NAME_EN, when defined, SHALL add input file_name (64 bits, char 0 in bits 63:56) and enable the NAME state.
REQ-030 NAME SHALL emit file_name characters from offset 13, up to 8, stopping before the first 0x00 character, then the terminator.
REQ-031 Without the macro, no file_name port SHALL exist, the terminator SHALL be at offset 13 and data SHALL start at offset 14.

Verification
REQ-032 type 0x80, autorun 1, range 0x0500..0x0502, RAM 11 22 33, out_ready tied 1 -> stream 16 16 16 24 00 00 80 C7 05 02 05 00 00 00 11 22 33; done pulses once; out_addr = 17.
REQ-033 Same stimulus with out_ready toggling 1/0 every cycle -> identical byte sequence; out_data and out_addr constant during each stall.
REQ-034 range 0x1000..0x0FFF -> 1-cycle error pulse; no out_valid, no mem_rd; busy stays 0.
REQ-035 range 0xFFFF..0xFFFF -> exactly one mem_rd at 0xFFFF; 15 bytes total; then done.
REQ-036 abort (or reset_n low) at data offset 15 -> out_valid 0 next cycle; no done; a new start then produces a full, correct file from offset 0.
REQ-037 With CASSETTE_SAVE_NAME_EN and file_name "AB" followed by 00s -> offsets 13..15 = 41 42 00; data starts at offset 16.

Source files
------------

// File: rtl/cassette_save_if.sv
// Bus bundle for cassette_save: RAM read port and the byte output stream.
//   mem_addr  - RAM byte address being read
//   mem_rd    - read strobe; mem_din is valid on the following cycle
//   mem_din   - RAM read data
//   out_data  - file byte presented to the sink
//   out_valid - out_data is valid
//   out_ready - sink accepts out_data on a cycle with out_valid high
//   out_addr  - byte offset of out_data within the file
// Modports: master = cassette_save side, slave = RAM/sink side.
interface cassette_save_if;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_din;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [24:0] out_addr;

   modport master (
      output mem_addr, mem_rd, out_data, out_valid, out_addr,
      input  mem_din, out_ready
   );

   modport slave (
      input  mem_addr, mem_rd, out_data, out_valid, out_addr,
      output mem_din, out_ready
   );
endinterface

// File: rtl/cassette_save.sv
// cassette_save: streams a TAP-style cassette file built from a header and a RAM range.
// Ports:
//   clk, reset_n         - clock, asynchronous active-low reset
//   start, abort         - begin a save (sampled in idle) / return to idle at once
//   file_type, autorun   - header type byte and autorun flag (latched at start)
//   start_addr, end_addr - inclusive RAM range to save (latched at start)
//   file_name            - 8 characters, char 0 in [63:56] (only with CASSETTE_SAVE_NAME_EN)
//   busy, done, error    - status: transfer active / 1-cycle completion / 1-cycle bad range
//   bus                  - RAM read port and output byte stream (cassette_save_if.master)
// Build option: define CASSETTE_SAVE_NAME_EN to add the file_name port and the name field.
module cassette_save (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   input  logic [7:0]         file_type,
   input  logic               autorun,
   input  logic [15:0]        start_addr,
   input  logic [15:0]        end_addr,
`ifdef CASSETTE_SAVE_NAME_EN
   input  logic [63:0]        file_name,
`endif
   output logic               busy,
   output logic               done,
   output logic               error,
   cassette_save_if.master    bus
);

   // StName is only reachable when the name field is built in.
   typedef enum logic [2:0] {
      StIdle, StHeader, StName, StFetch, StWait, StSend, StDone
   } state_e;

`ifdef CASSETTE_SAVE_NAME_EN
   localparam logic [3:0] LastHdr = 4'd12;  // name field follows the fixed header
`else
   localparam logic [3:0] LastHdr = 4'd13;  // offset 13 is the name terminator
`endif

   state_e      state_q, state_d;
   logic [3:0]  idx_q;
   logic [7:0]  type_q;
   logic        auto_q;
   logic [15:0] start_q, end_q, ptr_q;
   logic [16:0] cnt_q;                      // 17 bits so a full 64K range fits
   logic [7:0]  data_q;
   logic [24:0] addr_q;
   logic        error_q;
`ifdef CASSETTE_SAVE_NAME_EN
   logic [63:0] name_q;                     // shifted left per char; zeros fill in
`endif

   logic [7:0]  hdr_byte;
   logic [7:0]  out_data;
   logic        out_valid, mem_rd, accept;

   always_comb begin
      hdr_byte = 8'h00;
      case (idx_q)
         4'd0, 4'd1, 4'd2: hdr_byte = 8'h16;
         4'd3:             hdr_byte = 8'h24;
         4'd6:             hdr_byte = type_q;
         4'd7:             hdr_byte = auto_q ? 8'hC7 : 8'h00;
         4'd8:             hdr_byte = end_q[15:8];
         4'd9:             hdr_byte = end_q[7:0];
         4'd10:            hdr_byte = start_q[15:8];
         4'd11:            hdr_byte = start_q[7:0];
         default:          hdr_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      out_valid = 1'b0;
      out_data  = 8'h00;
      mem_rd    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         StIdle: begin
            if (start && (end_addr >= start_addr)) state_d = StHeader;
         end
         StHeader: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = hdr_byte;
            if (bus.out_ready && (idx_q == LastHdr)) begin
`ifdef CASSETTE_SAVE_NAME_EN
               state_d = StName;
`else
               state_d = StFetch;
`endif
            end
         end
`ifdef CASSETTE_SAVE_NAME_EN
         StName: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = name_q[63:56];      // a zero here is the terminator
            if (bus.out_ready && (name_q[63:56] == 8'h00)) state_d = StFetch;
         end
`endif
         StFetch: begin
            busy    = 1'b1;
            mem_rd  = 1'b1;
            state_d = StWait;
         end
         StWait: begin
            busy    = 1'b1;
            state_d = StSend;
         end
         StSend: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = data_q;
            if (bus.out_ready) state_d = (cnt_q == 17'd1) ? StDone : StFetch;
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (abort) state_d = StIdle;
   end

   assign accept        = out_valid && bus.out_ready;
   assign error         = error_q;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;
   assign bus.out_addr  = addr_q;
   assign bus.mem_rd    = mem_rd;
   assign bus.mem_addr  = ptr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         idx_q   <= 4'd0;
         type_q  <= 8'h00;
         auto_q  <= 1'b0;
         start_q <= 16'h0000;
         end_q   <= 16'h0000;
         ptr_q   <= 16'h0000;
         cnt_q   <= 17'd0;
         data_q  <= 8'h00;
         addr_q  <= 25'd0;
         error_q <= 1'b0;
`ifdef CASSETTE_SAVE_NAME_EN
         name_q  <= 64'd0;
`endif
      end else begin
         state_q <= state_d;
         error_q <= 1'b0;
         if (!abort) begin
            if (accept) addr_q <= addr_q + 25'd1;
            case (state_q)
               StIdle: begin
                  if (start) begin
                     if (end_addr >= start_addr) begin
                        type_q  <= file_type;
                        auto_q  <= autorun;
                        start_q <= start_addr;
                        end_q   <= end_addr;
                        ptr_q   <= start_addr;
                        cnt_q   <= {1'b0, end_addr} - {1'b0, start_addr} + 17'd1;
                        idx_q   <= 4'd0;
                        addr_q  <= 25'd0;
`ifdef CASSETTE_SAVE_NAME_EN
                        name_q  <= file_name;
`endif
                     end else begin
                        error_q <= 1'b1;
                     end
                  end
               end
               StHeader: if (accept) idx_q <= idx_q + 4'd1;
`ifdef CASSETTE_SAVE_NAME_EN
               StName:   if (accept) name_q <= {name_q[55:0], 8'h00};
`endif
               StWait:   data_q <= bus.mem_din;
               StSend: begin
                  // Pointer may wrap past 0xFFFF; cnt_q alone decides when to stop.
                  if (accept) begin
                     cnt_q <= cnt_q - 17'd1;
                     ptr_q <= ptr_q + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cassette_save.sv
// Directed bench for cassette_save: header/data stream, stalls, bad range, 0xFFFF range,
// abort and reset mid-file, start while busy.
module tb_cassette_save;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  file_type = 8'h00;
   logic        autorun = 1'b0;
   logic [15:0] start_addr = 16'h0000;
   logic [15:0] end_addr = 16'h0000;
`ifdef CASSETTE_SAVE_NAME_EN
   logic [63:0] file_name = {8'h41, 8'h42, 48'h0};
   localparam int DataOff = 16;
`else
   localparam int DataOff = 14;
`endif
   logic busy, done, error;

   cassette_save_if bus ();

   cassette_save dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .abort      (abort),
      .file_type  (file_type),
      .autorun    (autorun),
      .start_addr (start_addr),
      .end_addr   (end_addr),
`ifdef CASSETTE_SAVE_NAME_EN
      .file_name  (file_name),
`endif
      .busy       (busy),
      .done       (done),
      .error      (error),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ram(input logic [15:0] a);
      case (a)
         16'h0500: return 8'h11;
         16'h0501: return 8'h22;
         16'h0502: return 8'h33;
         16'hFFFF: return 8'hA5;
         default:  return 8'hEE;
      endcase
   endfunction

   initial bus.mem_din = 8'h00;
   always @(posedge clk) if (bus.mem_rd) bus.mem_din <= ram(bus.mem_addr);

   int total = 0;
   int bad = 0;
   logic [7:0]  got_data[$];
   logic [24:0] got_addr[$];
   logic [7:0]  exp_q[$];
   int done_cnt, err_cnt, rd_cnt, valid_cnt, busy_cnt, stall_cnt, stall_viol;
   logic [15:0] last_rd_addr;
   bit          tgl_en = 1'b0;
   bit          pend = 1'b0;
   logic [7:0]  pend_data;
   logic [24:0] pend_addr;

   initial bus.out_ready = 1'b1;

   // Monitor: set out_ready for the coming edge, then log what that edge will see.
   always @(negedge clk) begin
      bus.out_ready = tgl_en ? ~bus.out_ready : 1'b1;
      if (pend && bus.out_valid && (bus.out_data !== pend_data || bus.out_addr !== pend_addr))
         stall_viol++;
      pend      = bus.out_valid && !bus.out_ready;
      pend_data = bus.out_data;
      pend_addr = bus.out_addr;
      if (pend) stall_cnt++;
      if (bus.out_valid && bus.out_ready) begin
         got_data.push_back(bus.out_data);
         got_addr.push_back(bus.out_addr);
      end
      if (bus.out_valid) valid_cnt++;
      if (bus.mem_rd) begin
         rd_cnt++;
         last_rd_addr = bus.mem_addr;
      end
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic clear();
      got_data.delete();
      got_addr.delete();
      exp_q.delete();
      done_cnt = 0; err_cnt = 0; rd_cnt = 0; valid_cnt = 0;
      busy_cnt = 0; stall_cnt = 0; stall_viol = 0;
      pend = 1'b0;
   endtask

   // which=0: type 80 autorun 1 range 0500..0502; which=1: type 00 autorun 0 range FFFF..FFFF
   task automatic build_exp(input bit which);
      logic [7:0] hdr_a[13] = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00, 8'h80, 8'hC7,
                                8'h05, 8'h02, 8'h05, 8'h00, 8'h00};
      logic [7:0] hdr_b[13] = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
      for (int i = 0; i < 13; i++) exp_q.push_back(which ? hdr_b[i] : hdr_a[i]);
`ifdef CASSETTE_SAVE_NAME_EN
      exp_q.push_back(8'h41);
      exp_q.push_back(8'h42);
`endif
      exp_q.push_back(8'h00);
      if (which) exp_q.push_back(8'hA5);
      else begin
         exp_q.push_back(8'h11);
         exp_q.push_back(8'h22);
         exp_q.push_back(8'h33);
      end
   endtask

   task automatic kick(input logic [7:0] ft, input logic au, input logic [15:0] sa,
                       input logic [15:0] ea);
      @(negedge clk);
      file_type = ft; autorun = au; start_addr = sa; end_addr = ea;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 4000 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      @(negedge clk);
   endtask

   task automatic wait_addr15(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (bus.out_addr == 25'd15) seen = 1'b1;
      end
      check({tag, "_reach15"}, 32'(seen), 32'd1);
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_len"}, 32'(got_data.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_data.size()) begin
            check($sformatf("%s_d%0d", tag, i), 32'(got_data[i]), 32'(exp_q[i]));
            check($sformatf("%s_a%0d", tag, i), 32'(got_addr[i]), 32'(i));
         end
      end
   endtask

   task automatic full_run_a(input string tag);
      clear();
      build_exp(1'b0);
      kick(8'h80, 1'b1, 16'h0500, 16'h0502);
      wait_done(tag);
      check_stream(tag);
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_out_addr"}, 32'(bus.out_addr), 32'(DataOff + 3));
      check({tag, "_rd_cnt"}, 32'(rd_cnt), 32'd3);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_data", 32'(bus.out_data), 32'd0);
      check("rst_out_addr", 32'(bus.out_addr), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic file, with a bad-range start issued while busy that must be ignored
      clear();
      build_exp(1'b0);
      kick(8'h80, 1'b1, 16'h0500, 16'h0502);
      repeat (3) @(negedge clk);
      file_type = 8'h00; start_addr = 16'h1000; end_addr = 16'h0FFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("basic");
      check_stream("basic");
      check("basic_done_cnt", 32'(done_cnt), 32'd1);
      check("basic_out_addr", 32'(bus.out_addr), 32'(DataOff + 3));
      check("basic_rd_cnt", 32'(rd_cnt), 32'd3);
      check("basic_err_cnt", 32'(err_cnt), 32'd0);
      check("basic_busy_after", 32'(busy), 32'd0);
      repeat (4) @(negedge clk);
      check("basic_done_once", 32'(done_cnt), 32'd1);

      // Same file with out_ready toggling each cycle
      clear();
      build_exp(1'b0);
      tgl_en = 1'b1;
      kick(8'h80, 1'b1, 16'h0500, 16'h0502);
      wait_done("stall");
      tgl_en = 1'b0;
      check_stream("stall");
      check("stall_viol", 32'(stall_viol), 32'd0);
      check("stall_seen", 32'(stall_cnt != 0), 32'd1);
      check("stall_done_cnt", 32'(done_cnt), 32'd1);
      repeat (2) @(negedge clk);

      // Bad range
      clear();
      kick(8'h00, 1'b0, 16'h1000, 16'h0FFF);
      repeat (4) @(negedge clk);
      check("bad_err_cnt", 32'(err_cnt), 32'd1);
      check("bad_valid_cnt", 32'(valid_cnt), 32'd0);
      check("bad_rd_cnt", 32'(rd_cnt), 32'd0);
      check("bad_busy_cnt", 32'(busy_cnt), 32'd0);

      // Single byte at 0xFFFF
      clear();
      build_exp(1'b1);
      kick(8'h00, 1'b0, 16'hFFFF, 16'hFFFF);
      wait_done("ffff");
      check_stream("ffff");
      check("ffff_rd_cnt", 32'(rd_cnt), 32'd1);
      check("ffff_rd_addr", 32'(last_rd_addr), 32'hFFFF);
      check("ffff_out_addr", 32'(bus.out_addr), 32'(DataOff + 1));
      check("ffff_done_cnt", 32'(done_cnt), 32'd1);
      repeat (4) @(negedge clk);
      check("ffff_no_extra_rd", 32'(rd_cnt), 32'd1);

      // Abort at offset 15
      clear();
      kick(8'h80, 1'b1, 16'h0500, 16'h0502);
      wait_addr15("abort");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_valid", 32'(bus.out_valid), 32'd0);
      check("abort_mem_rd", 32'(bus.mem_rd), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      check("abort_no_done", 32'(done_cnt), 32'd0);
      full_run_a("after_abort");
      repeat (2) @(negedge clk);

      // Reset at offset 15
      clear();
      kick(8'h80, 1'b1, 16'h0500, 16'h0502);
      wait_addr15("rstmid");
      reset_n = 1'b0;
      #1;
      check("rstmid_valid", 32'(bus.out_valid), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_out_addr", 32'(bus.out_addr), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check("rstmid_no_done", 32'(done_cnt), 32'd0);
      full_run_a("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
